// File: rtl/tetris_input_sequencer.sv
// rtl/tetris_input_sequencer.sv - button edge/auto-repeat capture with round-robin command issue
module tetris_input_sequencer #(
  parameter int CNT_W      = 19,
  parameter int DAS_DELAY  = 250000,
  parameter int ARR_PERIOD = 50000
) (
  input  logic       vclk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_rotate,
  input  logic       btn_drop,
  input  logic       game_active,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [1:0] cmd_code,
  output logic       cmd_repeat
);

  localparam logic [CNT_W-1:0] C_DAS_LAST = CNT_W'(DAS_DELAY - 1);
  localparam logic [CNT_W-1:0] C_ARR_LAST = CNT_W'(ARR_PERIOD - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  // Index order matches cmd_code: rotate=0, left=1, right=2, drop=3.
  logic [3:0]       w_btn;
  logic [3:0]       w_press;
  logic [3:0]       w_expire;
  logic [3:0]       w_set;
  logic [3:0]       w_clr;
  logic [3:0]       w_req;
  logic [3:0]       w_lock;
  logic             w_any;
  logic [1:0]       w_sel;
  logic [1:0]       w_idx;

  logic [3:0]       r_prev;
  logic [3:0]       r_pend;
  logic [3:0]       r_pend_rep;
  logic [CNT_W-1:0] r_timer [1:3];
  logic [3:1]       r_phase;       // 0 = waiting out the initial delay, 1 = repeating
  logic [1:0]       r_ptr;
  state_t           r_state;
  logic             r_cmd_valid;
  logic [1:0]       r_cmd_code;
  logic             r_cmd_repeat;

  assign w_btn   = {btn_drop, btn_right, btn_left, btn_rotate};
  assign w_press = w_btn & ~r_prev;
  // Left+right together freezes both repeat timers; drop keeps repeating.
  assign w_lock  = {1'b0, btn_left & btn_right, btn_left & btn_right, 1'b0};
  assign w_set   = (w_press | w_expire) & {4{game_active}};
  assign w_clr   = (r_state == S_ISSUE && cmd_ready) ? (4'd1 << r_cmd_code) : 4'd0;
  assign w_req   = r_pend & {4{game_active}};

  assign cmd_valid  = r_cmd_valid;
  assign cmd_code   = r_cmd_code;
  assign cmd_repeat = r_cmd_repeat;

  // Repeat expiry: a held (not newly pressed, not locked) button whose timer hit its phase limit.
  always_comb begin
    w_expire = '0;
    for (int i = 1; i < 4; i++) begin
      w_expire[i] = game_active & w_btn[i] & r_prev[i] & ~w_lock[i] &
                    (r_timer[i] == (r_phase[i] ? C_ARR_LAST : C_DAS_LAST));
    end
  end

  // Round-robin search for the first pending button starting at the pointer.
  always_comb begin
    w_any = 1'b0;
    w_sel = r_ptr;
    w_idx = '0;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_any && w_req[w_idx]) begin
        w_any = 1'b1;
        w_sel = w_idx;
      end
    end
  end

  // Previous-level register; loading it in reset suppresses edges from buttons held through reset.
  always_ff @(posedge vclk) begin
    r_prev <= w_btn;
  end

  // Repeat timers for left, right and drop.
  always_ff @(posedge vclk) begin
    for (int i = 1; i < 4; i++) begin
      if (rst || !game_active || !w_btn[i] || w_press[i] || w_lock[i]) begin
        r_timer[i] <= '0;
        r_phase[i] <= 1'b0;
      end else if (w_expire[i]) begin
        r_timer[i] <= '0;
        r_phase[i] <= 1'b1;
      end else begin
        r_timer[i] <= r_timer[i] + CNT_W'(1);
      end
    end
  end

  // Pending flags: a set beats a same-cycle grant clear; repeated sets saturate.
  always_ff @(posedge vclk) begin
    if (rst || !game_active) begin
      r_pend     <= '0;
      r_pend_rep <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_set;
      for (int i = 0; i < 4; i++) begin
        if (w_set[i]) begin
          r_pend_rep[i] <= w_expire[i];
        end
      end
    end
  end

  // Command channel FSM: grant in IDLE, hold the command stable in ISSUE until accepted.
  always_ff @(posedge vclk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_cmd_valid  <= 1'b0;
      r_cmd_code   <= '0;
      r_cmd_repeat <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_cmd_code   <= w_sel;
            r_cmd_repeat <= r_pend_rep[w_sel];
            r_cmd_valid  <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_ptr       <= r_cmd_code + 2'd1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/tetris_input_sequencer.md
Name: tetris_input_sequencer

Overview:
- Sits between the four per-button debouncers (left, right, rotate, drop) and the game-logic FSM.
- Turns debounced button levels into discrete move commands. Detects press edges and generates auto-repeat (initial delay, then a fixed rate) for left, right and drop.
- Round-robin arbitrates the four buttons onto one command channel with a valid/ready handshake, so no button event is lost while game logic is busy.

Parameters:
- CNT_W, 19, width of each repeat timer; must hold DAS_DELAY-1 and ARR_PERIOD-1.
- DAS_DELAY, 250000, vclk cycles a repeatable button is held before its first repeat (>=2).
- ARR_PERIOD, 50000, vclk cycles between subsequent repeats (>=2).

Ports:
- vclk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- btn_left  in  1  debounced level, 1 = pressed.
- btn_right  in  1  debounced level.
- btn_rotate  in  1  debounced level.
- btn_drop  in  1  debounced level.
- game_active  in  1  1 = accept input; 0 = flush and ignore buttons.
- cmd_ready  in  1  game logic accepts the command this cycle.
- cmd_valid  out  1  command available.
- cmd_code  out  2  0 = rotate, 1 = left, 2 = right, 3 = drop.
- cmd_repeat  out  1  1 = command came from auto-repeat, 0 = from a press edge.

Behaviour:
- Button indices: rotate=0, left=1, right=2, drop=3.

Reset (rst=1 at a vclk edge):
- cmd_valid=0, cmd_code=0, cmd_repeat=0.
- Pending flags cleared; repeat timers cleared; RR pointer=0; state=IDLE.
- prev[i] loads the current btn level, so a button already held during reset produces no event.
- rst mid-handshake drops the command without waiting for cmd_ready.

Edge detection:
- Each cycle: press[i] = btn[i] & ~prev[i]; then prev[i] <= btn[i].

Pending flags:
- pend[i] and pend_rep[i] are set on the cycle after press, or on repeat expiry.
- A set into an already-pending flag is absorbed: no counting, no error.
- pend_rep[i] records the most recent source of the pending event.
- pend[i] survives button release, so short taps are never lost.
- Grant clears pend[i] on the accept cycle. If a new set hits the same cycle, the set wins and pend stays 1.

Repeat timers (left, right, drop only; rotate never repeats):
- On press: timer <= 0, phase <= DAS.
- While held: timer increments. At DAS_DELAY-1 (DAS phase) or ARR_PERIOD-1 (ARR phase): set pend with pend_rep=1, timer <= 0, phase <= ARR.
- Release: timer <= 0, phase <= DAS.
- While btn_left and btn_right are both 1: both timers are held at 0 in phase DAS. Press edges still register.

game_active=0:
- All pend cleared, timers at 0, no new captures. prev keeps tracking the buttons.
- A cmd_valid already asserted stays until accepted.

FSM:
- IDLE: if any pend, grant the first pending index searching from ptr upward, mod 4. Register cmd_code=index and cmd_repeat=pend_rep[index]; cmd_valid <= 1; go to ISSUE.
- ISSUE: cmd_valid, cmd_code and cmd_repeat are held stable. On cmd_ready=1: clear pend[granted], ptr <= granted+1 mod 4, cmd_valid <= 0, return to IDLE.
- At most one command per 2 cycles.
- cmd_ready while in IDLE is ignored.

Latency:
- Button rises before edge k, so press is sampled at edge k.
- pend set after edge k; cmd_valid high after edge k+1, when the channel is idle.

Widths:
- Timers are CNT_W unsigned and never wrap; the compare resets them first.
- ptr is 2 bits and wraps 3 -> 0.

Test Plan:
- Reset with btn_rotate=1, then hold 10 cycles, cmd_ready=1 -> cmd_valid never asserts. Release and press again -> cmd_valid exactly 2 cycles after the rise, cmd_code=0, cmd_repeat=0.
- DAS_DELAY=8, ARR_PERIOD=4, cmd_ready=1, hold btn_left 30 cycles -> one edge command (code 1, repeat 0), then repeat commands (code 1, repeat 1) at 8 cycles after the press, then every 4 cycles; none after release.
- cmd_ready=0; pulse rotate, left, right and drop on the same cycle. Then cmd_ready=1 -> exactly four commands in order 0,1,2,3; each code stable while waiting; ptr ends at 0.
- Pulse rotate twice while the first command is stalled (cmd_ready=0) -> only one rotate issued after ready, because the pending flag saturates.
- Hold btn_left and btn_right together for 40 cycles, DAS_DELAY=8 -> exactly two commands (codes 1 and 2, repeat 0), no repeats.
- Press drop, then game_active=0 before grant -> no command issued. Assert rst during ISSUE -> cmd_valid=0 next cycle.
